// File: rtl/serial_add_sched.sv
// Round-robin two-requester scheduler driving an internal bit-serial LSB-first adder.
// Optional subtract mode (sub0/sub1 ports) is enabled by defining SERADD_SUB_EN.
module serial_add_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
`ifdef SERADD_SUB_EN
  input  logic             sub0,
  input  logic             sub1,
`endif
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             busy,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             carry, carry_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] r_sr, r_sr_nxt;
  logic             rr_last, rr_last_nxt;
  logic             busy_nxt, done_nxt, done_id_nxt, cout_nxt;
  logic [1:0]       gnt_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             pick;
  logic             sub_sel;
  logic             s;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      rr_last <= 1'b1;
      busy    <= 1'b0;
      gnt     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      carry   <= carry_nxt;
      a_sr    <= a_sr_nxt;
      b_sr    <= b_sr_nxt;
      r_sr    <= r_sr_nxt;
      rr_last <= rr_last_nxt;
      busy    <= busy_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      done_id <= done_id_nxt;
      sum     <= sum_nxt;
      cout    <= cout_nxt;
    end
  end

  // Next-state, arbitration and one serial add step per RUN cycle
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    carry_nxt   = carry;
    a_sr_nxt    = a_sr;
    b_sr_nxt    = b_sr;
    r_sr_nxt    = r_sr;
    rr_last_nxt = rr_last;
    busy_nxt    = busy;
    gnt_nxt     = gnt;
    done_nxt    = 1'b0;
    done_id_nxt = done_id;
    sum_nxt     = sum;
    cout_nxt    = cout;
    pick        = (req0 && req1) ? ~rr_last : req1;
    sub_sel     = 1'b0;
`ifdef SERADD_SUB_EN
    sub_sel     = pick ? sub1 : sub0;
`endif
    s           = a_sr[0] ^ b_sr[0] ^ carry;

    unique case (state)
      IDLE: begin
        // The cycle done is visible still belongs to the finished operation
        if (done) begin
          busy_nxt = 1'b0;
          gnt_nxt  = 2'b00;
        end else if (req0 || req1) begin
          a_sr_nxt  = pick ? a1 : a0;
          b_sr_nxt  = (pick ? b1 : b0) ^ {WIDTH{sub_sel}};
          carry_nxt = sub_sel;
          cnt_nxt   = '0;
          gnt_nxt   = pick ? 2'b10 : 2'b01;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        a_sr_nxt  = a_sr >> 1;
        b_sr_nxt  = b_sr >> 1;
        r_sr_nxt  = {s, r_sr[WIDTH-1:1]};
        cnt_nxt   = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        done_nxt    = 1'b1;
        sum_nxt     = r_sr;
        cout_nxt    = carry;
        done_id_nxt = gnt[1];
        rr_last_nxt = gnt[1];
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
